fetch_unit: RTL and testbench

Parametrised instruction-fetch stage. Holds the program counter and an on-chip instruction memory that can be loaded through a write port. Each cycle it delivers one instruction word into a pipeline buffer for decode. It arbitrates redirects in priority order (interrupt, execute-stage jump, decode-stage direct jump, sequential), and it runs an interrupt save handshake before vectoring.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with loadable instruction memory and interrupt save handshake
module fetch_unit #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] INT_VEC   = 16'h0010,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              jump_occured,
    input  logic [ADDR_W-1:0] jump_to,
    input  logic              direct_jump,
    input  logic [ADDR_W-1:0] direct_jump_to,
    input  logic              interrupt,
    output logic [DATA_W-1:0] instr_buf,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              save_interrupt_data,
    output logic [ADDR_W-1:0] int_ret_pc
);

    // A one-word memory still needs a one-bit index so the slices below stay legal.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_INT_SAVE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_buf_q, instr_buf_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              save_q, save_d;
    logic [ADDR_W-1:0] int_ret_pc_q, int_ret_pc_d;
    logic              int_pending_q, int_pending_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              accept_int;

    // Only the low address bits select a memory word; the rest alias.
    generate
        if (IDX_W < ADDR_W) begin : g_unused_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^write_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // Combinational read; the registered capture of this word sees the pre-write value.
    assign rd_word    = mem[pc_q[IDX_W-1:0]];
    assign accept_int = (interrupt | int_pending_q) & ~stall;

    // Synchronous load port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr[IDX_W-1:0]] <= write_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter save on interrupt acceptance, leave once the pipeline is not stalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:      if (accept_int) state_d = S_INT_SAVE;
            S_INT_SAVE: if (!stall)     state_d = S_RUN;
            default:    state_d = S_RUN;
        endcase
    end

    // Datapath next values: redirect arbitration in priority interrupt > exec jump > decode jump > stall > fetch.
    always_comb begin
        pc_d          = pc_q;
        instr_buf_d   = instr_buf_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        int_ret_pc_d  = int_ret_pc_q;
        int_pending_d = int_pending_q;
        case (state_q)
            S_RUN: begin
                if (accept_int) begin
                    // Return to wherever the pipeline was about to go, so a redirect in flight is not lost.
                    if (jump_occured) begin
                        int_ret_pc_d = jump_to;
                    end else if (direct_jump) begin
                        int_ret_pc_d = direct_jump_to;
                    end else begin
                        int_ret_pc_d = pc_q;
                    end
                    instr_buf_d   = NOP_WORD;
                    instr_valid_d = 1'b0;
                    int_pending_d = 1'b0;
                end else begin
                    int_pending_d = int_pending_q | interrupt;
                    if (jump_occured) begin
                        pc_d          = jump_to;
                        instr_buf_d   = NOP_WORD;
                        instr_valid_d = 1'b0;
                    end else if (direct_jump) begin
                        pc_d          = direct_jump_to;
                        instr_buf_d   = NOP_WORD;
                        instr_valid_d = 1'b0;
                    end else if (!stall) begin
                        instr_buf_d   = rd_word;
                        pc_out_d      = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_INT_SAVE: begin
                // Requests arriving here merge into the one being serviced; jumps are ignored.
                instr_buf_d   = NOP_WORD;
                instr_valid_d = 1'b0;
                if (!stall) begin
                    pc_d = INT_VEC;
                end
            end
            default: begin
                instr_valid_d = 1'b0;
            end
        endcase
        save_d = (state_d == S_INT_SAVE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            instr_buf_q   <= NOP_WORD;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
            save_q        <= 1'b0;
            int_ret_pc_q  <= '0;
            int_pending_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_buf_q   <= instr_buf_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
            save_q        <= save_d;
            int_ret_pc_q  <= int_ret_pc_d;
            int_pending_q <= int_pending_d;
        end
    end

    assign instr_buf           = instr_buf_q;
    assign instr_valid         = instr_valid_q;
    assign pc_out              = pc_out_q;
    assign save_interrupt_data = save_q;
    assign int_ret_pc          = int_ret_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        write_enable;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        jump_occured;
    logic [15:0] jump_to;
    logic        direct_jump;
    logic [15:0] direct_jump_to;
    logic        interrupt;
    logic [15:0] instr_buf;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic        save_interrupt_data;
    logic [15:0] int_ret_pc;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .write_enable        (write_enable),
        .write_addr          (write_addr),
        .write_data          (write_data),
        .jump_occured        (jump_occured),
        .jump_to             (jump_to),
        .direct_jump         (direct_jump),
        .direct_jump_to      (direct_jump_to),
        .interrupt           (interrupt),
        .instr_buf           (instr_buf),
        .instr_valid         (instr_valid),
        .pc_out              (pc_out),
        .save_interrupt_data (save_interrupt_data),
        .int_ret_pc          (int_ret_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic exp_fetch(input string tag, input logic [15:0] w, input logic [15:0] p);
        check({tag, "_buf"},   32'(instr_buf),   32'(w));
        check({tag, "_pc"},    32'(pc_out),      32'(p));
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic exp_bubble(input string tag);
        check({tag, "_buf"},   32'(instr_buf),   32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; write_enable = 1'b0; write_addr = '0; write_data = '0;
        jump_occured = 1'b0; jump_to = '0; direct_jump = 1'b0; direct_jump_to = '0; interrupt = 1'b0;

        // Load the program while reset is held.
        load(16'h0000, 16'h1111);
        load(16'h0001, 16'h2222);
        load(16'h0002, 16'h3333);
        load(16'h0003, 16'h4444);
        load(16'h0004, 16'h5555);
        load(16'h0005, 16'h6666);
        load(16'h0006, 16'h7777);
        load(16'h0007, 16'h8888);
        load(16'h0010, 16'hB010);
        load(16'h0011, 16'hB011);
        load(16'h0020, 16'hA020);
        load(16'h0021, 16'hA021);
        load(16'h0040, 16'hC040);
        load(16'h03FF, 16'hDEAD);

        check("rst_buf",   32'(instr_buf),           32'h0);
        check("rst_valid", 32'(instr_valid),         32'd0);
        check("rst_pcout", 32'(pc_out),              32'h0);
        check("rst_save",  32'(save_interrupt_data), 32'd0);
        check("rst_ret",   32'(int_ret_pc),          32'h0);
        rst = 1'b1;

        // Sequential fetch.
        tick(); exp_fetch("seq0", 16'h1111, 16'h0000);
        tick(); exp_fetch("seq1", 16'h2222, 16'h0001);

        // Stall for three edges at pc=2.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); exp_fetch("stall", 16'h2222, 16'h0001);
        end
        stall = 1'b0;
        tick(); exp_fetch("resume2", 16'h3333, 16'h0002);
        tick(); exp_fetch("seq3",    16'h4444, 16'h0003);
        tick(); exp_fetch("seq4",    16'h5555, 16'h0004);

        // Interrupt at pc=5, no stall.
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        exp_bubble("int_acc");
        check("int_acc_save", 32'(save_interrupt_data), 32'd1);
        check("int_acc_ret",  32'(int_ret_pc),          32'h0005);
        tick();
        exp_bubble("int_exit");
        check("int_exit_save", 32'(save_interrupt_data), 32'd0);
        tick(); exp_fetch("int_vec", 16'hB010, 16'h0010);

        // Simultaneous execute and decode jumps: execute wins.
        jump_occured = 1'b1; jump_to = 16'h0020;
        direct_jump = 1'b1;  direct_jump_to = 16'h0040;
        tick();
        jump_occured = 1'b0; direct_jump = 1'b0;
        exp_bubble("jmp_bub");
        tick(); exp_fetch("jmp_tgt",  16'hA020, 16'h0020);
        tick(); exp_fetch("jmp_next", 16'hA021, 16'h0021);

        // Interrupt pulsed under stall is latched, save held by further stall.
        stall = 1'b1; interrupt = 1'b1;
        tick();
        interrupt = 1'b0; stall = 1'b0;
        exp_fetch("pend_hold", 16'hA021, 16'h0021);
        check("pend_hold_save", 32'(save_interrupt_data), 32'd0);
        tick();
        stall = 1'b1;
        check("pend_acc_save", 32'(save_interrupt_data), 32'd1);
        check("pend_acc_ret",  32'(int_ret_pc),          32'h0022);
        check("pend_acc_valid", 32'(instr_valid),        32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("pend_save_held", 32'(save_interrupt_data), 32'd1);
            check("pend_ret_held",  32'(int_ret_pc),          32'h0022);
        end
        stall = 1'b0;
        tick();
        check("pend_exit_save", 32'(save_interrupt_data), 32'd0);
        exp_bubble("pend_exit");
        tick(); exp_fetch("pend_vec", 16'hB010, 16'h0010);

        // Same-cycle write and fetch of address 7 returns the old word.
        direct_jump = 1'b1; direct_jump_to = 16'h0007;
        tick();
        direct_jump = 1'b0;
        exp_bubble("dj7_bub");
        write_enable = 1'b1; write_addr = 16'h0007; write_data = 16'hBEEF;
        tick();
        write_enable = 1'b0;
        exp_fetch("wr_old", 16'h8888, 16'h0007);
        direct_jump = 1'b1; direct_jump_to = 16'h0007;
        tick();
        direct_jump = 1'b0;
        tick(); exp_fetch("wr_new", 16'hBEEF, 16'h0007);

        // PC wrap at the top of the address space; memory index aliases.
        jump_occured = 1'b1; jump_to = 16'hFFFF;
        tick();
        jump_occured = 1'b0;
        tick(); exp_fetch("wrap_top",  16'hDEAD, 16'hFFFF);
        tick(); exp_fetch("wrap_zero", 16'h1111, 16'h0000);

        // Interrupt with simultaneous jump: jump target becomes the return address.
        interrupt = 1'b1; jump_occured = 1'b1; jump_to = 16'h0030;
        tick();
        interrupt = 1'b0; jump_occured = 1'b0;
        check("intj_save", 32'(save_interrupt_data), 32'd1);
        check("intj_ret",  32'(int_ret_pc),          32'h0030);
        stall = 1'b1;
        tick();
        check("intj_save_held", 32'(save_interrupt_data), 32'd1);

        // Asynchronous reset in the middle of the save handshake.
        #2 rst = 1'b0;
        #1;
        check("arst_save",  32'(save_interrupt_data), 32'd0);
        check("arst_ret",   32'(int_ret_pc),          32'h0);
        check("arst_pcout", 32'(pc_out),              32'h0);
        exp_bubble("arst");
        rst = 1'b1; stall = 1'b0;
        tick();
        exp_fetch("arst_run", 16'h1111, 16'h0000);
        check("arst_run_save", 32'(save_interrupt_data), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
